// File: rtl/fighter_pkg.sv
// Shared encodings for the fighter motion unit: player states, colours,
// motion-FSM modes and a saturating x helper.
package fighter_pkg;

    // Player FSM states as driven by the game controller
    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_BACKWARD     = 3'd1;
    localparam logic [2:0] ST_FORWARD      = 3'd2;
    localparam logic [2:0] ST_ATK_START    = 3'd3;
    localparam logic [2:0] ST_ATK_ACTIVE   = 3'd4;
    localparam logic [2:0] ST_ATK_RECOVERY = 3'd5;

    // RGB332 fill colours
    localparam logic [7:0] COL_NORMAL       = 8'h03;
    localparam logic [7:0] COL_ATK_START    = 8'hE0;
    localparam logic [7:0] COL_ATK_ACTIVE   = 8'hFC;
    localparam logic [7:0] COL_ATK_RECOVERY = 8'h1F;
    localparam logic [7:0] COL_UNDEF        = 8'hFF;
    localparam logic [7:0] KB_COLOR         = 8'h92;

    // Motion FSM modes
    localparam logic [0:0] MODE_MOVE      = 1'b0;
    localparam logic [0:0] MODE_KNOCKBACK = 1'b1;

    // Colour for a player state outside of knockback
    function automatic logic [7:0] state_color(input logic [2:0] s);
        case (s)
            ST_IDLE, ST_BACKWARD, ST_FORWARD: state_color = COL_NORMAL;
            ST_ATK_START:                     state_color = COL_ATK_START;
            ST_ATK_ACTIVE:                    state_color = COL_ATK_ACTIVE;
            ST_ATK_RECOVERY:                  state_color = COL_ATK_RECOVERY;
            default:                          state_color = COL_UNDEF;
        endcase
    endfunction

    // Squeeze a 12-bit signed coordinate into [0, hi] as a 10-bit value
    function automatic logic [9:0] sat10(input logic signed [11:0] v, input logic signed [11:0] hi);
        if (v < 12'sd0)
            sat10 = 10'd0;
        else if (v > hi)
            sat10 = hi[9:0];
        else
            sat10 = v[9:0];
    endfunction

endpackage

// File: rtl/x_step_clamp.sv
// One saturating x step: move x by step in the given direction, never
// crossing lo/hi. If x already sits beyond the bound it is heading toward,
// it holds instead of being snapped back.
module x_step_clamp #(
    parameter int W = 12
) (
    input  logic signed [W-1:0] x,
    input  logic                dir_pos,
    input  logic        [W-1:0] step,
    input  logic signed [W-1:0] lo,
    input  logic signed [W-1:0] hi,
    output logic signed [W-1:0] nx
);

    logic signed [W-1:0] t;

    // Candidate position, then saturate against the bound in the travel direction
    always_comb begin
        t  = dir_pos ? (x + $signed(step)) : (x - $signed(step));
        nx = t;
        if (dir_pos && (t > hi))
            nx = (x > hi) ? x : hi;
        else if (!dir_pos && (t < lo))
            nx = (x < lo) ? x : lo;
    end

endmodule

// File: rtl/fighter_motion_unit.sv
// Per-fighter motion and appearance: frame-gated walking with opponent
// collision, multi-frame knockback, sprite colour and attack hitbox.
module fighter_motion_unit
    import fighter_pkg::*;
#(
    parameter int SCREEN_W  = 640,
    parameter int SPRITE_W  = 64,
    parameter int X_INIT    = 100,
    parameter int Y_POS     = 100,
    parameter int FWD_STEP  = 3,
    parameter int BACK_STEP = 2,
    parameter int FACE_LEFT = 0,
    parameter int KB_STEP   = 4,
    parameter int KB_FRAMES = 6,
    parameter int HIT_W     = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic [2:0] state,
    input  logic [9:0] opp_x,
    input  logic       kb_req,
    output logic [9:0] sprite_x,
    output logic [9:0] sprite_y,
    output logic [7:0] sprite_color,
    output logic       in_knockback,
    output logic       hitbox_valid,
    output logic [9:0] hitbox_x
);

    // 12-bit signed internal coordinates so opp_x + SPRITE_W cannot overflow
    localparam int XW = 12;
    localparam logic signed [XW-1:0] XMAX_S = XW'(SCREEN_W - SPRITE_W);
    localparam logic signed [XW-1:0] HMAX_S = XW'(SCREEN_W - HIT_W);
    localparam logic signed [XW-1:0] SW_S   = XW'(SPRITE_W);
    localparam logic signed [XW-1:0] HW_S   = XW'(HIT_W);
    localparam logic [XW-1:0] FWD_S  = XW'(FWD_STEP);
    localparam logic [XW-1:0] BACK_S = XW'(BACK_STEP);
    localparam logic [XW-1:0] KB_S   = XW'(KB_STEP);
    localparam logic          FL     = (FACE_LEFT != 0);
    // The consuming tick is the first knockback frame, so the counter
    // holds the frames still to go after it.
    localparam logic [3:0]    KB_LOAD  = 4'(KB_FRAMES - 1);
    localparam logic [0:0]    KB_ENTER = (KB_FRAMES > 1) ? MODE_KNOCKBACK : MODE_MOVE;

    logic [9:0]          x_q;
    logic [0:0]          mode_q;
    logic                kb_pending;
    logic [3:0]          kb_cnt;
    logic                kb_take;
    logic signed [XW-1:0] xs, opp, fwd_lim, lo, hi, nx, hx_raw;
    logic                dirp;
    logic [XW-1:0]       step;

    assign xs      = $signed({2'b00, x_q});
    assign opp     = $signed({2'b00, opp_x});
    assign kb_take = frame_tick & (kb_pending | kb_req);

    // Forward collision limit against the opponent, kept on screen
    always_comb begin
        if (!FL) begin
            fwd_lim = opp - SW_S;
            if (fwd_lim < 12'sd0) fwd_lim = 12'sd0;
            if (fwd_lim > XMAX_S) fwd_lim = XMAX_S;
        end else begin
            fwd_lim = opp + SW_S;
            if (fwd_lim > XMAX_S) fwd_lim = XMAX_S;
        end
    end

    // Choose this tick's move: knockback overrides the player state
    always_comb begin
        dirp = FL;              // "backward" is +x when facing left
        step = '0;
        lo   = 12'sd0;
        hi   = XMAX_S;
        if (kb_take || (mode_q == MODE_KNOCKBACK)) begin
            step = KB_S;
        end else begin
            case (state)
                ST_FORWARD: begin
                    dirp = !FL;
                    step = FWD_S;
                    if (FL) lo = fwd_lim;
                    else    hi = fwd_lim;
                end
                ST_BACKWARD: step = BACK_S;
                default:     step = '0;
            endcase
        end
    end

    x_step_clamp #(.W(XW)) u_clamp (
        .x       (xs),
        .dir_pos (dirp),
        .step    (step),
        .lo      (lo),
        .hi      (hi),
        .nx      (nx)
    );

    // Position, knockback request latch and motion FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q        <= 10'(X_INIT);
            mode_q     <= MODE_MOVE;
            kb_pending <= 1'b0;
            kb_cnt     <= 4'd0;
        end else begin
            kb_pending <= frame_tick ? 1'b0 : (kb_pending | kb_req);
            if (frame_tick) begin
                x_q <= sat10(nx, XMAX_S);
                if (kb_take) begin
                    kb_cnt <= KB_LOAD;
                    mode_q <= KB_ENTER;
                end else if (mode_q == MODE_KNOCKBACK) begin
                    kb_cnt <= kb_cnt - 4'd1;
                    if (kb_cnt == 4'd1) mode_q <= MODE_MOVE;
                end
            end
        end
    end

    // Hitbox edge in front of the sprite, clamped on screen
    always_comb begin
        if (!FL) begin
            hx_raw = xs + SW_S;
            if (hx_raw > HMAX_S) hx_raw = HMAX_S;
        end else begin
            hx_raw = xs - HW_S;
            if (hx_raw < 12'sd0) hx_raw = 12'sd0;
        end
    end

    // Registered appearance: colour and hitbox follow state/position by one clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sprite_color <= COL_NORMAL;
            hitbox_valid <= 1'b0;
            hitbox_x     <= 10'd0;
        end else begin
            sprite_color <= (mode_q == MODE_KNOCKBACK) ? KB_COLOR : state_color(state);
            hitbox_valid <= (state == ST_ATK_ACTIVE) && (mode_q == MODE_MOVE);
            hitbox_x     <= ((state == ST_ATK_ACTIVE) && (mode_q == MODE_MOVE)) ?
                            sat10(hx_raw, HMAX_S) : 10'd0;
        end
    end

    assign sprite_x     = x_q;
    assign sprite_y     = 10'(Y_POS);
    assign in_knockback = (mode_q == MODE_KNOCKBACK);

endmodule

// File: tb/tb_fighter_motion_unit.sv
// Scoreboard bench: two fighters (facing right / facing left) share the
// frame tick; each tick pushes hand-derived expectations, a monitor pops
// and compares once the registered outputs have settled.
module tb_fighter_motion_unit;

    logic       clk = 1'b0, rst_n = 1'b0, ft = 1'b0;
    logic [2:0] st0 = 3'd0, st1 = 3'd0;
    logic [9:0] opp0 = 10'd500, opp1 = 10'd0;
    logic       kb0 = 1'b0, kb1 = 1'b0;
    logic [9:0] x0, y0, hx0, x1, y1, hx1;
    logic [7:0] c0, c1;
    logic       ik0, hv0, ik1, hv1;

    always #5 clk = ~clk;

    fighter_motion_unit u0 (
        .clk(clk), .rst_n(rst_n), .frame_tick(ft), .state(st0), .opp_x(opp0), .kb_req(kb0),
        .sprite_x(x0), .sprite_y(y0), .sprite_color(c0), .in_knockback(ik0),
        .hitbox_valid(hv0), .hitbox_x(hx0)
    );

    fighter_motion_unit #(.FACE_LEFT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .frame_tick(ft), .state(st1), .opp_x(opp1), .kb_req(kb1),
        .sprite_x(x1), .sprite_y(y1), .sprite_color(c1), .in_knockback(ik1),
        .hitbox_valid(hv1), .hitbox_x(hx1)
    );

    typedef struct {
        logic [9:0] x0; logic k0; logic [7:0] c0; logic v0; logic [9:0] h0;
        logic [9:0] x1; logic [7:0] c1; logic v1; logic [9:0] h1;
        int tag;
    } exp_t;

    exp_t q[$];
    int n_run = 0, n_fail = 0, tagc = 0;
    // Expected fighter-1 outputs, held per phase
    logic [9:0] e1x = 10'd100, e1h = 10'd0;
    logic [7:0] e1c = 8'h03;
    logic       e1v = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: results of a tick are fully visible two edges after it is sampled
    logic td1 = 1'b0, td2 = 1'b0;
    always @(posedge clk) begin
        td1 <= ft;
        td2 <= td1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (td2) begin
            if (q.size() == 0) begin
                n_run++; n_fail++;
                $display("FAIL sb_empty: got tick with no expectation, expected a queued entry");
            end else begin
                e = q.pop_front();
                chk($sformatf("x0[%0d]", e.tag),  32'(x0),  32'(e.x0));
                chk($sformatf("kb0[%0d]", e.tag), 32'(ik0), 32'(e.k0));
                chk($sformatf("col0[%0d]", e.tag), 32'(c0), 32'(e.c0));
                chk($sformatf("hv0[%0d]", e.tag), 32'(hv0), 32'(e.v0));
                chk($sformatf("hx0[%0d]", e.tag), 32'(hx0), 32'(e.h0));
                chk($sformatf("x1[%0d]", e.tag),  32'(x1),  32'(e.x1));
                chk($sformatf("col1[%0d]", e.tag), 32'(c1), 32'(e.c1));
                chk($sformatf("hv1[%0d]", e.tag), 32'(hv1), 32'(e.v1));
                chk($sformatf("hx1[%0d]", e.tag), 32'(hx1), 32'(e.h1));
            end
        end
    end

    // One frame tick with fighter-0 expectations; kb optionally pulsed on the same cycle
    task automatic tick(input logic [9:0] x, input logic k, input logic [7:0] c,
                        input logic v, input logic [9:0] h, input logic kb = 1'b0);
        exp_t e;
        e.x0 = x; e.k0 = k; e.c0 = c; e.v0 = v; e.h0 = h;
        e.x1 = e1x; e.c1 = e1c; e.v1 = e1v; e.h1 = e1h;
        e.tag = tagc++;
        q.push_back(e);
        @(negedge clk); ft = 1'b1; kb0 = kb;
        @(negedge clk); ft = 1'b0; kb0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_kb();
        @(negedge clk); kb0 = 1'b1;
        @(negedge clk); kb0 = 1'b0;
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_x0",  32'(x0),  32'd100);
        chk("rst_y0",  32'(y0),  32'd100);
        chk("rst_col", 32'(c0),  32'h03);
        chk("rst_kb",  32'(ik0), 32'd0);
        chk("rst_hv",  32'(hv0), 32'd0);
        chk("rst_hx",  32'(hx0), 32'd0);
        rst_n = 1'b1;

        // Frame gating: FORWARD with no tick for 100 clocks
        st0 = 3'd2; st1 = 3'd2;
        repeat (100) @(negedge clk);
        chk("gate_x0", 32'(x0), 32'd100);
        chk("gate_x1", 32'(x1), 32'd100);

        // Forward walk: fighter 0 stops at 500-64=436, fighter 1 stops at 0+64=64
        for (int k = 1; k <= 114; k++) begin
            e1x = (k < 12) ? 10'(100 - 3 * k) : 10'd64;
            tick((k <= 112) ? 10'(100 + 3 * k) : 10'd436, 1'b0, 8'h03, 1'b0, 10'd0);
        end

        // Back off to 300
        st0 = 3'd1; st1 = 3'd0;
        for (int k = 1; k <= 68; k++)
            tick(10'(436 - 2 * k), 1'b0, 8'h03, 1'b0, 10'd0);

        // Attack stance: fighter 1 hitbox 64-32=32, fighter 0 hitbox 300+64
        st0 = 3'd4; st1 = 3'd4;
        e1c = 8'hFC; e1v = 1'b1; e1h = 10'd32;
        tick(10'd300, 1'b0, 8'hFC, 1'b1, 10'd364);

        // Knockback from 300; double request while pending is absorbed
        pulse_kb();
        pulse_kb();
        for (int k = 1; k <= 6; k++)
            tick(10'(300 - 4 * k), (k < 6), (k < 6) ? 8'h92 : 8'hFC, (k == 6),
                 (k == 6) ? 10'd340 : 10'd0);

        // Request on the tick itself, reload after tick 3: nine frames
        st0 = 3'd0;
        for (int k = 1; k <= 9; k++) begin
            tick(10'(276 - 4 * k), (k < 9), (k < 9) ? 8'h92 : 8'h03, 1'b0, 10'd0, (k == 1));
            if (k == 3) pulse_kb();
        end

        // Walk back to 10, then knockback saturates at the left edge
        st0 = 3'd1;
        for (int k = 1; k <= 115; k++)
            tick(10'(240 - 2 * k), 1'b0, 8'h03, 1'b0, 10'd0);
        st0 = 3'd0;
        pulse_kb();
        for (int k = 1; k <= 6; k++)
            tick((10 - 4 * k > 0) ? 10'(10 - 4 * k) : 10'd0, (k < 6),
                 (k < 6) ? 8'h92 : 8'h03, 1'b0, 10'd0);

        // Forward to 15, then backward 13..1,0 and hold without wrapping
        st0 = 3'd2;
        for (int k = 1; k <= 5; k++)
            tick(10'(3 * k), 1'b0, 8'h03, 1'b0, 10'd0);
        st0 = 3'd1;
        for (int k = 1; k <= 9; k++)
            tick((15 - 2 * k > 0) ? 10'(15 - 2 * k) : 10'd0, 1'b0, 8'h03, 1'b0, 10'd0);

        // Reset in the middle of a knockback with another request pending
        st0 = 3'd0; st1 = 3'd0;
        e1c = 8'h03; e1v = 1'b0; e1h = 10'd0;
        tick(10'd0, 1'b1, 8'h92, 1'b0, 10'd0, 1'b1);
        pulse_kb();
        @(negedge clk); rst_n = 1'b0;
        #1;
        chk("mid_rst_x0",  32'(x0),  32'd100);
        chk("mid_rst_kb",  32'(ik0), 32'd0);
        chk("mid_rst_col", 32'(c0),  32'h03);
        chk("mid_rst_hv",  32'(hv0), 32'd0);
        chk("mid_rst_hx",  32'(hx0), 32'd0);
        chk("mid_rst_x1",  32'(x1),  32'd100);
        @(negedge clk); rst_n = 1'b1;
        // Dropped request must not start a knockback
        e1x = 10'd100;
        tick(10'd100, 1'b0, 8'h03, 1'b0, 10'd0);

        repeat (5) @(negedge clk);
        if (q.size() != 0) begin
            n_run++; n_fail++;
            $display("FAIL sb_drain: got %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
